// File: rtl/uart_tx_fifo_if.sv
// CPU-side register bus for the UART transmit channel (IO_UART device slot).
interface uart_tx_fifo_if;
    logic       cs;
    logic       wr;
    logic       rd;
    logic [1:0] addr;
    logic [7:0] in_data;
    logic [7:0] out_data;

    modport master (output cs, wr, rd, addr, in_data, input out_data);
    modport slave  (input cs, wr, rd, addr, in_data, output out_data);
endinterface

// File: rtl/uart_tx_fifo.sv
// Memory-mapped 8N1 UART transmitter with a byte FIFO, status/count/ctrl registers and FIFO-empty irq.
// Optional parity bit (CTRL bit2 selects odd) is compiled in when UART_TX_PARITY_EN is defined.
module uart_tx_fifo #(
    parameter int unsigned BAUD_DIV   = 87,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic          clk,
    input  logic          reset,
    uart_tx_fifo_if.slave bus,
    output logic          tx_out,
    output logic          irq,
    output logic          busy
);
    localparam int unsigned      PTR_W     = $clog2(FIFO_DEPTH);
    localparam int unsigned      CNT_W     = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C   = CNT_W'(FIFO_DEPTH);
    localparam logic [15:0]      BAUD_LAST = 16'(BAUD_DIV - 1);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;
`else
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;
`endif

    logic [7:0]       mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q, count_d;
    logic             ovf_q, ovf_d;
    logic             irq_en_q;
    logic [7:0]       out_data_q;
    logic             irq_q;
`ifdef UART_TX_PARITY_EN
    logic             odd_q;
    logic             parity_q;
`endif

    state_e           state_q;
    logic [7:0]       shift_q;
    logic [2:0]       bit_idx_q;
    logic [15:0]      baud_q;
    logic             tx_q;
    logic             busy_q;

    logic full, empty, wr_en, rd_en, push_req, ctrl_wr, flush, push, pop, baud_last;
    logic [7:0] rd_val;

    assign full      = (count_q == DEPTH_C);
    assign empty     = (count_q == '0);
    assign wr_en     = bus.cs & bus.wr;
    assign rd_en     = bus.cs & bus.rd;
    assign push_req  = wr_en && (bus.addr == 2'd1);
    assign ctrl_wr   = wr_en && (bus.addr == 2'd2);
    assign flush     = ctrl_wr & bus.in_data[1];
    // Fullness is judged before any same-cycle pop; flush discards a same-cycle push.
    assign push      = push_req & ~full & ~flush;
    assign pop       = (state_q == IDLE) & ~empty;
    assign baud_last = (baud_q == BAUD_LAST);

    always_comb begin
        count_d = count_q;
        if (flush) begin
            count_d = '0;
        end else if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop && !push) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_comb begin
        ovf_d = ovf_q;
        if (push_req && full && !flush) begin
            ovf_d = 1'b1;
        end else if (rd_en && bus.addr == 2'd0) begin
            ovf_d = 1'b0;
        end
    end

    always_comb begin
        rd_val = '0;
        case (bus.addr)
            2'd0: rd_val = {4'b0, ovf_q, empty, full, busy_q};
            2'd1: rd_val = '0;
`ifdef UART_TX_PARITY_EN
            2'd2: rd_val = {5'b0, odd_q, 1'b0, irq_en_q};
`else
            2'd2: rd_val = {7'b0, irq_en_q};
`endif
            2'd3: rd_val = 8'(count_q);
        endcase
    end

    // NOTE: FIFO storage is deliberately left out of reset; count_q alone decides which entries are valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= bus.in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            ovf_q      <= 1'b0;
            irq_en_q   <= 1'b0;
            out_data_q <= '0;
            irq_q      <= 1'b0;
`ifdef UART_TX_PARITY_EN
            odd_q      <= 1'b0;
`endif
        end else begin
            count_q <= count_d;
            ovf_q   <= ovf_d;
            irq_q   <= irq_en_q & empty & ~busy_q;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (flush) begin
                rd_ptr_q <= wr_ptr_q;
            end else if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            if (ctrl_wr) begin
                irq_en_q <= bus.in_data[0];
`ifdef UART_TX_PARITY_EN
                odd_q    <= bus.in_data[2];
`endif
            end
            if (rd_en) begin
                out_data_q <= rd_val;
            end
        end
    end

    // tx_q lags state_q by one clock, which places the start bit two edges after the push.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            bit_idx_q <= '0;
            baud_q    <= '0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    tx_q <= 1'b1;
                    if (!empty) begin
                        shift_q   <= mem_q[rd_ptr_q];
`ifdef UART_TX_PARITY_EN
                        parity_q  <= (^mem_q[rd_ptr_q]) ^ odd_q;
`endif
                        bit_idx_q <= '0;
                        baud_q    <= '0;
                        busy_q    <= 1'b1;
                        state_q   <= START;
                    end
                end
                START: begin
                    tx_q <= 1'b0;
                    if (baud_last) begin
                        baud_q  <= '0;
                        state_q <= DATA;
                    end else begin
                        baud_q <= baud_q + 16'd1;
                    end
                end
                DATA: begin
                    tx_q <= shift_q[0];
                    if (baud_last) begin
                        baud_q    <= '0;
                        shift_q   <= shift_q >> 1;
                        bit_idx_q <= bit_idx_q + 3'd1;
                        if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            state_q <= PARITY;
`else
                            state_q <= STOP;
`endif
                        end
                    end else begin
                        baud_q <= baud_q + 16'd1;
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    tx_q <= parity_q;
                    if (baud_last) begin
                        baud_q  <= '0;
                        state_q <= STOP;
                    end else begin
                        baud_q <= baud_q + 16'd1;
                    end
                end
`endif
                STOP: begin
                    tx_q <= 1'b1;
                    if (baud_last) begin
                        baud_q  <= '0;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        baud_q <= baud_q + 16'd1;
                    end
                end
                default: begin
                    tx_q    <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign tx_out       = tx_q;
    assign busy         = busy_q;
    assign irq          = irq_q;
    assign bus.out_data = out_data_q;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: directed scenarios plus random bus traffic against a
// queue-and-frame-timeline model. Define UART_TX_PARITY_EN to exercise the parity build.
`timescale 1ns/1ps
module tb_uart_tx_fifo;
    localparam int BAUD  = 4;
    localparam int DEPTH = 8;
`ifdef UART_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int FRAME = NBITS * BAUD;

    logic clk = 1'b0;
    logic reset;
    logic tx_out, irq, busy;

    uart_tx_fifo_if bus ();

    uart_tx_fifo #(.BAUD_DIV(BAUD), .FIFO_DEPTH(DEPTH)) dut (
        .clk    (clk),
        .reset  (reset),
        .bus    (bus),
        .tx_out (tx_out),
        .irq    (irq),
        .busy   (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: byte queue plus the position within the frame currently on the line.
    byte unsigned m_q[$];
    logic       m_ovf, m_irq_en, m_odd;
    int         m_pos;
    logic [7:0] m_byte;
    logic       m_par;
    logic       m_busy, m_tx, m_irq;
    logic [7:0] m_out;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Line level for bit slot k: start, 8 data bits LSB first, optional parity, stop.
    function automatic logic line_bit(input int k);
        if (k == 0) return 1'b0;
        if (k <= 8) return m_byte[k-1];
        if (NBITS == 11 && k == 9) return m_par;
        return 1'b1;
    endfunction

    function automatic logic [10:0] frame_of(input logic [7:0] b, input logic odd);
        logic [10:0] f;
        f      = '1;
        f[0]   = 1'b0;
        f[8:1] = b;
        if (NBITS == 11) f[9] = (^b) ^ odd;
        return f;
    endfunction

    task automatic model_step();
        int   cnt;
        logic full_pre, empty_pre, busy_pre, rd_en, wr_en, flush, popped, ovf_set;
        if (reset) begin
            m_q.delete();
            m_ovf = 0; m_irq_en = 0; m_odd = 0; m_pos = -1;
            m_busy = 0; m_tx = 1; m_irq = 0; m_out = '0;
        end else begin
            cnt       = m_q.size();
            full_pre  = (cnt == DEPTH);
            empty_pre = (cnt == 0);
            busy_pre  = m_busy;
            rd_en     = bus.cs && bus.rd;
            wr_en     = bus.cs && bus.wr;
            flush     = wr_en && bus.addr == 2'd2 && bus.in_data[1];
            popped    = 0;
            ovf_set   = 0;
            if (rd_en) begin
                case (bus.addr)
                    2'd0: m_out = {4'b0, m_ovf, empty_pre, full_pre, busy_pre};
                    2'd1: m_out = 8'h00;
`ifdef UART_TX_PARITY_EN
                    2'd2: m_out = {5'b0, m_odd, 1'b0, m_irq_en};
`else
                    2'd2: m_out = {7'b0, m_irq_en};
`endif
                    default: m_out = 8'(cnt);
                endcase
            end
            m_irq = m_irq_en && empty_pre && !busy_pre;
            if (m_pos >= 0) begin
                m_pos++;
                m_tx   = line_bit((m_pos - 1) / BAUD);
                m_busy = (m_pos < FRAME);
                if (m_pos == FRAME) m_pos = -1;
            end else begin
                m_tx = 1'b1;
                if (!empty_pre) begin
                    m_byte = m_q[0];
                    m_par  = (^m_byte) ^ m_odd;
                    m_pos  = 0;
                    m_busy = 1'b1;
                    popped = 1;
                end
            end
            if (wr_en && bus.addr == 2'd2) begin
                m_irq_en = bus.in_data[0];
`ifdef UART_TX_PARITY_EN
                m_odd = bus.in_data[2];
`endif
            end
            if (flush) begin
                m_q.delete();
            end else begin
                if (popped) void'(m_q.pop_front());
                if (wr_en && bus.addr == 2'd1) begin
                    if (full_pre) begin
                        m_ovf   = 1'b1;
                        ovf_set = 1;
                    end else begin
                        m_q.push_back(bus.in_data);
                    end
                end
            end
            if (rd_en && bus.addr == 2'd0 && !ovf_set) m_ovf = 1'b0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check("tx_out", tx_out, m_tx);
        check("busy", busy, m_busy);
        check("irq", irq, m_irq);
        check("out_data", bus.out_data, m_out);
    endtask

    task automatic idle_bus();
        bus.cs = 0; bus.wr = 0; bus.rd = 0;
    endtask

    task automatic write_reg(input logic [1:0] a, input logic [7:0] d);
        bus.cs = 1; bus.wr = 1; bus.rd = 0; bus.addr = a; bus.in_data = d;
        tick();
        idle_bus();
    endtask

    task automatic read_reg(input logic [1:0] a, output logic [7:0] v);
        bus.cs = 1; bus.rd = 1; bus.wr = 0; bus.addr = a;
        tick();
        v = bus.out_data;
        idle_bus();
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) tick();
    endtask

    // Push one byte into an idle, empty channel and check every line bit and the busy width.
    task automatic check_frame(input logic [7:0] b, input logic odd, input string tag);
        logic [10:0] f;
        int          busy_cnt;
        f = frame_of(b, odd);
        write_reg(2'd1, b);
        tick();
        check({tag, "_pop_tx"}, tx_out, 1'b1);
        busy_cnt = int'(busy);
        for (int i = 0; i < FRAME; i++) begin
            tick();
            check({tag, "_bit"}, tx_out, f[i / BAUD]);
            busy_cnt += int'(busy);
        end
        check({tag, "_busy_len"}, busy_cnt, FRAME);
    endtask

    initial begin
        logic [7:0] v;
        int         r, rises, low_run, highs;
        logic       prev_busy, seen, done;

        reset = 1'b1;
        idle_bus();
        bus.addr = 2'd0;
        bus.in_data = 8'h00;
        tick();
        tick();
        reset = 1'b0;
        read_reg(2'd0, v);
        check("reset_status", v, 8'h04);

        // Single frame bit timing.
        check_frame(8'hA5, 1'b0, "a5");
        tick();

        // CTRL bit2 is only stored in the parity build.
        write_reg(2'd2, 8'h04);
        read_reg(2'd2, v);
`ifdef UART_TX_PARITY_EN
        check("ctrl_odd", v, 8'h04);
`else
        check("ctrl_odd", v, 8'h00);
`endif
        write_reg(2'd2, 8'h00);

`ifdef UART_TX_PARITY_EN
        check_frame(8'h07, 1'b0, "par_even");
        write_reg(2'd2, 8'h04);
        check_frame(8'h07, 1'b1, "par_odd");
        write_reg(2'd2, 8'h00);
`endif

        // Back-to-back frames separated by exactly one idle clock, polling COUNT.
        write_reg(2'd1, 8'h01);
        write_reg(2'd1, 8'h02);
        write_reg(2'd1, 8'h03);
        prev_busy = busy;
        rises = 0;
        low_run = 0;
        bus.cs = 1; bus.rd = 1; bus.addr = 2'd3;
        for (int i = 0; i < 3 * (FRAME + 1) + 4; i++) begin
            tick();
            if (busy && !prev_busy) begin
                rises++;
                check("b2b_gap", low_run, 1);
            end
            low_run = busy ? 0 : low_run + 1;
            prev_busy = busy;
        end
        idle_bus();
        check("b2b_frames", rises, 2);

        // Overflow: one popped, eight stored, tenth dropped.
        for (int i = 0; i < 10; i++) write_reg(2'd1, 8'(8'h10 + i));
        read_reg(2'd0, v);
        check("ovf_status", v, 8'h0B);
        read_reg(2'd0, v);
        check("ovf_cleared", v, 8'h03);
        wait_cycles(9 * (FRAME + 1) + 4);
        read_reg(2'd3, v);
        check("drained_count", v, 8'h00);

        // FIFO-empty interrupt.
        write_reg(2'd2, 8'h01);
        wait_cycles(2);
        check("irq_idle", irq, 1'b1);
        write_reg(2'd1, 8'h5A);
        seen = 0;
        done = 0;
        for (int i = 0; i < FRAME + 10 && !done; i++) begin
            tick();
            if (busy) seen = 1;
            else if (seen) done = 1;
        end
        check("irq_wait_busy_fall", done, 1'b1);
        check("irq_at_busy_fall", irq, 1'b0);
        tick();
        check("irq_after_stop", irq, 1'b1);
        write_reg(2'd2, 8'h00);
        tick();
        check("irq_disabled", irq, 1'b0);

        // Flush while the first byte is in its data bits.
        for (int i = 0; i < 4; i++) write_reg(2'd1, 8'(8'hC0 + i));
        wait_cycles(BAUD + 2);
        write_reg(2'd2, 8'h02);
        read_reg(2'd3, v);
        check("flush_count", v, 8'h00);
        wait_cycles(FRAME);
        highs = 0;
        for (int i = 0; i < 2 * FRAME; i++) begin
            tick();
            highs += int'(busy);
        end
        check("flush_no_frames", highs, 0);

        // Reset in the middle of a frame.
        write_reg(2'd1, 8'h3C);
        wait_cycles(3 * BAUD);
        read_reg(2'd0, v);
        check("midframe_status", v, 8'h05);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rst_tx", tx_out, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_out_data", bus.out_data, 8'h00);
        tick();

        // Random traffic against the model.
        for (int i = 0; i < 2000; i++) begin
            r = int'($urandom_range(0, 199));
            idle_bus();
            reset = 1'b0;
            bus.addr = 2'($urandom);
            bus.in_data = 8'($urandom);
            if (r < 20) begin
                bus.cs = 1; bus.wr = 1; bus.addr = 2'd1;
            end else if (r < 24) begin
                bus.cs = 1; bus.wr = 1; bus.addr = 2'd2;
                bus.in_data = {5'b0, 1'($urandom), (r == 20), 1'($urandom)};
            end else if (r < 60) begin
                bus.cs = 1; bus.rd = 1;
            end else if (r < 70) begin
                bus.wr = 1; bus.rd = 1;
            end else if (r == 199) begin
                reset = 1'b1;
            end
            tick();
        end
        idle_bus();
        reset = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
